// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS core: forwarding selects,
// the hardwired zero register and the default register-address width.
package pipe_pkg;

  localparam int PIPE_REGW = 5;
  localparam int ZERO_REG  = 0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

endpackage

// File: rtl/md_busy_counter.sv
// Busy countdown for the multi-cycle multiply/divide unit: busy for exactly
// MDLAT cycles after an op leaves E; starts while busy are ignored.
module md_busy_counter #(
  parameter int MDLAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  logic [7:0] mdcnt_q;
  logic [7:0] mdcnt_d;

  // Next-state: load on an accepted start, otherwise count down to zero.
  always_comb begin
    mdcnt_d = mdcnt_q;
    if (start && (mdcnt_q == 8'd0)) begin
      mdcnt_d = 8'(MDLAT);
    end else if (mdcnt_q != 8'd0) begin
      mdcnt_d = mdcnt_q - 8'd1;
    end else begin
      mdcnt_d = mdcnt_q;
    end
  end

  // Countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdcnt_q <= 8'd0;
    end else begin
      mdcnt_q <= mdcnt_d;
    end
  end

  assign busy = (mdcnt_q != 8'd0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the F/D/E/M/W pipeline: forwarding selects, load/branch/
// multiply-divide interlocks and a saturating stalled-cycle counter.
module hazard_unit_mc
  import pipe_pkg::*;
#(
  parameter int REGW  = PIPE_REGW,
  parameter int MDLAT = 4,
  parameter int PCW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            mdstartE,
  input  logic            mduseD,
  output logic            stallF,
  output logic            stallD,
  output logic            flushE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            mdbusy,
  output logic [PCW-1:0]  stallcnt
);

  localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

  logic           lwstall_s;
  logic           branchstall_s;
  logic           mdstall_s;
  logic           stall_s;
  logic           mdbusy_s;
  logic [PCW-1:0] stallcnt_q;
  logic [PCW-1:0] stallcnt_d;

  function automatic logic [1:0] fwd_sel(
    input logic [REGW-1:0] src,
    input logic            rw_m,
    input logic [REGW-1:0] wr_m,
    input logic            rw_w,
    input logic [REGW-1:0] wr_w
  );
    logic [1:0] sel;
    if ((src != ZR) && rw_m && (src == wr_m)) begin
      sel = FWD_MEM;
    end else if ((src != ZR) && rw_w && (src == wr_w)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  md_busy_counter #(.MDLAT(MDLAT)) u_md_busy (
    .clk   (clk),
    .reset (reset),
    .start (mdstartE),
    .busy  (mdbusy_s)
  );

  // Forwarding selects and interlock causes, all zero-latency.
  always_comb begin
    forwardAE = fwd_sel(rsE, regwriteM, writeregM, regwriteW, writeregW);
    forwardBE = fwd_sel(rtE, regwriteM, writeregM, regwriteW, writeregW);
    forwardAD = (rsD != ZR) && regwriteM && (rsD == writeregM);
    forwardBD = (rtD != ZR) && regwriteM && (rtD == writeregM);
    lwstall_s = memtoregE && regwriteE && (writeregE != ZR) &&
                ((writeregE == rsD) || (writeregE == rtD));
    branchstall_s = branchD &&
                    ((regwriteE && (writeregE != ZR) &&
                      ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && (writeregM != ZR) &&
                      ((writeregM == rsD) || (writeregM == rtD))));
    mdstall_s = mduseD && mdbusy_s;
    stall_s   = lwstall_s || branchstall_s || mdstall_s;
  end

  assign stallF = stall_s;
  assign stallD = stall_s;
  assign flushE = stall_s;
  assign mdbusy = mdbusy_s;

  // Stalled-cycle counter next state, saturating at all-ones.
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (stall_s && (stallcnt_q != {PCW{1'b1}})) begin
      stallcnt_d = stallcnt_q + PCW'(1);
    end else begin
      stallcnt_d = stallcnt_q;
    end
  end

  // Stalled-cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallcnt_q <= {PCW{1'b0}};
    end else begin
      stallcnt_q <= stallcnt_d;
    end
  end

  assign stallcnt = stallcnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc (MDLAT=4); a second
// instance with PCW=4 shares the stimulus to exercise counter saturation.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, mdstartE, mduseD;

  logic        stallF, stallD, flushE, forwardAD, forwardBD, mdbusy;
  logic [1:0]  forwardAE, forwardBE;
  logic [15:0] stallcnt;

  logic        s_stallF, s_stallD, s_flushE, s_forwardAD, s_forwardBD, s_mdbusy;
  logic [1:0]  s_forwardAE, s_forwardBE;
  logic [3:0]  s_stallcnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REGW(5), .MDLAT(4), .PCW(16)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdstartE(mdstartE), .mduseD(mduseD), .stallF(stallF), .stallD(stallD),
    .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .mdbusy(mdbusy),
    .stallcnt(stallcnt)
  );

  hazard_unit_mc #(.REGW(5), .MDLAT(4), .PCW(4)) u_sat (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdstartE(mdstartE), .mduseD(mduseD), .stallF(s_stallF), .stallD(s_stallD),
    .flushE(s_flushE), .forwardAD(s_forwardAD), .forwardBD(s_forwardBD),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE), .mdbusy(s_mdbusy),
    .stallcnt(s_stallcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
    writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
    mdstartE = 1'b0; mduseD = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    tick();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mdbusy} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 0", {stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE, mdbusy});
    end
    tests++;
    if (stallcnt !== 16'd0) begin fails++; $display("FAIL reset_stallcnt: got %0d expected 0", stallcnt); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_forward_e();
    clear_inputs();
    regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8;
    #1;
    tests++;
    if (forwardAE !== 2'b10) begin fails++; $display("FAIL fwdAE_mem: got %b expected 10", forwardAE); end
    writeregM = 5'd0; rsE = 5'd0;
    #1;
    tests++;
    if (forwardAE !== 2'b00) begin fails++; $display("FAIL fwdAE_zero: got %b expected 00", forwardAE); end
    regwriteM = 1'b1; writeregM = 5'd9; regwriteW = 1'b1; writeregW = 5'd9; rtE = 5'd9;
    #1;
    tests++;
    if (forwardBE !== 2'b10) begin fails++; $display("FAIL fwdBE_prio: got %b expected 10", forwardBE); end
    regwriteM = 1'b0;
    #1;
    tests++;
    if (forwardBE !== 2'b01) begin fails++; $display("FAIL fwdBE_wb: got %b expected 01", forwardBE); end
    rsE = 5'd9;
    #1;
    tests++;
    if (forwardAE !== 2'b01) begin fails++; $display("FAIL fwdAE_wb: got %b expected 01", forwardAE); end
    regwriteW = 1'b0;
    #1;
    tests++;
    if ({forwardAE, forwardBE} !== 4'b0000) begin fails++; $display("FAIL fwd_none: got %b expected 0000", {forwardAE, forwardBE}); end
  endtask

  task automatic test_forward_d();
    clear_inputs();
    regwriteM = 1'b1; writeregM = 5'd4; rsD = 5'd4; rtD = 5'd6;
    #1;
    tests++;
    if ({forwardAD, forwardBD} !== 2'b10) begin fails++; $display("FAIL fwdD_a: got %b expected 10", {forwardAD, forwardBD}); end
    rsD = 5'd7; rtD = 5'd4;
    #1;
    tests++;
    if ({forwardAD, forwardBD} !== 2'b01) begin fails++; $display("FAIL fwdD_b: got %b expected 01", {forwardAD, forwardBD}); end
    regwriteM = 1'b0;
    #1;
    tests++;
    if ({forwardAD, forwardBD} !== 2'b00) begin fails++; $display("FAIL fwdD_nowr: got %b expected 00", {forwardAD, forwardBD}); end
  endtask

  task automatic test_lwstall();
    do_reset();
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
    #1;
    tests++;
    if ({stallF, stallD, flushE} !== 3'b111) begin fails++; $display("FAIL lwstall_on: got %b expected 111", {stallF, stallD, flushE}); end
    tests++;
    if (stallcnt !== 16'd0) begin fails++; $display("FAIL lwstall_cnt0: got %0d expected 0", stallcnt); end
    tick();
    tests++;
    if (stallcnt !== 16'd1) begin fails++; $display("FAIL lwstall_cnt1: got %0d expected 1", stallcnt); end
    clear_inputs();
    #1;
    tests++;
    if ({stallF, stallD, flushE} !== 3'b000) begin fails++; $display("FAIL lwstall_off: got %b expected 000", {stallF, stallD, flushE}); end
    tick();
    tests++;
    if (stallcnt !== 16'd1) begin fails++; $display("FAIL lwstall_hold: got %0d expected 1", stallcnt); end
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd0; rtD = 5'd0;
    #1;
    tests++;
    if (stallF !== 1'b0) begin fails++; $display("FAIL lwstall_r0: got %b expected 0", stallF); end
  endtask

  task automatic test_branchstall();
    clear_inputs();
    branchD = 1'b1; rsD = 5'd3; memtoregM = 1'b1; writeregM = 5'd3;
    #1;
    tests++;
    if (stallD !== 1'b1) begin fails++; $display("FAIL brstall_m: got %b expected 1", stallD); end
    writeregM = 5'd0; rsD = 5'd0;
    #1;
    tests++;
    if (stallD !== 1'b0) begin fails++; $display("FAIL brstall_r0: got %b expected 0", stallD); end
    clear_inputs();
    branchD = 1'b1; rtD = 5'd12; regwriteE = 1'b1; writeregE = 5'd12;
    #1;
    tests++;
    if (flushE !== 1'b1) begin fails++; $display("FAIL brstall_e: got %b expected 1", flushE); end
    branchD = 1'b0;
    #1;
    tests++;
    if (flushE !== 1'b0) begin fails++; $display("FAIL brstall_nobr: got %b expected 0", flushE); end
  endtask

  task automatic test_mdstall();
    do_reset();
    mdstartE = 1'b1; mduseD = 1'b1;
    #1;
    tests++;
    if ({mdbusy, stallF} !== 2'b00) begin fails++; $display("FAIL md_start: got %b expected 00", {mdbusy, stallF}); end
    tick();
    mdstartE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({mdbusy, stallF} !== 2'b11) begin fails++; $display("FAIL md_busy%0d: got %b expected 11", i, {mdbusy, stallF}); end
      tick();
    end
    tests++;
    if ({mdbusy, stallF} !== 2'b00) begin fails++; $display("FAIL md_done: got %b expected 00", {mdbusy, stallF}); end
    tests++;
    if (stallcnt !== 16'd4) begin fails++; $display("FAIL md_cnt: got %0d expected 4", stallcnt); end
  endtask

  task automatic test_md_ignore_and_reset();
    do_reset();
    mdstartE = 1'b1;
    tick();
    mdstartE = 1'b0; mduseD = 1'b1;
    tick();
    tick();
    mdstartE = 1'b1;
    tick();
    mdstartE = 1'b0;
    tick();
    tests++;
    if (mdbusy !== 1'b0) begin fails++; $display("FAIL md_ignore: got %b expected 0", mdbusy); end
    tests++;
    if (stallcnt !== 16'd4) begin fails++; $display("FAIL md_ignore_cnt: got %0d expected 4", stallcnt); end
    do_reset();
    mdstartE = 1'b1;
    tick();
    mdstartE = 1'b0; mduseD = 1'b1;
    tick();
    tick();
    tests++;
    if ({mdbusy, stallcnt} !== {1'b1, 16'd2}) begin fails++; $display("FAIL md_mid: got %b/%0d expected 1/2", mdbusy, stallcnt); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if ({mdbusy, stallcnt, stallF} !== {1'b0, 16'd0, 1'b0}) begin fails++; $display("FAIL md_async_rst: got %b/%0d/%b expected 0/0/0", mdbusy, stallcnt, stallF); end
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rsD = 5'd5;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    tests++;
    if (s_stallcnt !== 4'd15) begin fails++; $display("FAIL sat_pcw4: got %0d expected 15", s_stallcnt); end
    tests++;
    if (stallcnt !== 16'd20) begin fails++; $display("FAIL sat_pcw16: got %0d expected 20", stallcnt); end
    clear_inputs();
    tick();
    tests++;
    if (s_stallcnt !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d expected 15", s_stallcnt); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forward_e();
    test_forward_d();
    test_lwstall();
    test_branchstall();
    test_mdstall();
    test_md_ignore_and_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor of the 5-stage pipeline hazard unit.
- Generates stalls, flushes and forwarding selects for the F/D/E/M/W MIPS pipeline.
- Adds interlocking for a multi-cycle multiply/divide unit via a busy countdown.
- Adds a saturating stall-cycle performance counter.
- Sits beside the controller and datapath in the pipelined top level.

Parameters:
- REGW, 5, register address width; address 0 is the hardwired zero register.
- MDLAT, 4, cycles the multiply/divide unit stays busy after an op leaves E; legal range 1..255.
- PCW, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- rsD, rtD  in  REGW  source registers of the instruction in D
- rsE, rtE  in  REGW  source registers of the instruction in E
- writeregE, writeregM, writeregW  in  REGW  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
- memtoregE, memtoregM  in  1  load in E / load in M
- branchD  in  1  branch being resolved in D
- mdstartE  in  1  multiply/divide op in E (starts the unit this cycle)
- mduseD  in  1  D instruction needs the multiply/divide unit or HI/LO (mult, div, mfhi, mflo)
- stallF, stallD  out  1  hold PC / hold the F/D register
- flushE  out  1  clear the D/E register (inserts a bubble)
- forwardAD, forwardBD  out  1  D-stage comparator forward from M
- forwardAE, forwardBE  out  2  E-stage ALU operand select
- mdbusy  out  1  multiply/divide unit busy
- stallcnt  out  PCW  saturating count of stalled cycles

Behaviour:
- forwardAE:
  - FWD_MEM (2'b10) if rsE!=0 && regwriteM && rsE==writeregM.
  - Else FWD_WB (2'b01) if rsE!=0 && regwriteW && rsE==writeregW.
  - Else FWD_NONE (2'b00).
  - M takes priority over W. forwardBE is the same using rtE.
- forwardAD = rsD!=0 && regwriteM && rsD==writeregM. forwardBD uses rtD the same way.
- lwstall = memtoregE && regwriteE && writeregE!=0 && (writeregE==rsD || writeregE==rtD).
- branchstall = branchD && (
  - (regwriteE && writeregE!=0 && writeregE in {rsD,rtD}), or
  - (memtoregM && writeregM!=0 && writeregM in {rsD,rtD})).
- mdstall = mduseD && mdbusy.
- stall = lwstall | branchstall | mdstall. stallF = stallD = flushE = stall.
- All of the above are combinational, with zero latency.
- Busy counter (mdcnt, 8 bits):
  - Reset value is 0. mdbusy = (mdcnt != 0).
  - On a clock edge with mdstartE && !mdbusy, mdcnt loads MDLAT.
  - Else if mdcnt != 0, mdcnt decrements by 1.
  - Result: mdbusy is high for exactly MDLAT cycles, starting the cycle after mdstartE.
  - mdstartE while mdbusy cannot occur legally, because mdstall blocks it. If it does occur, it is ignored: no reload, and the countdown continues.
- stallcnt:
  - Reset value is 0. Increments on each edge where stall=1.
  - Saturates at all-ones and holds there.
- Reset mid-operation: mdcnt and stallcnt clear immediately (asynchronous), and mdbusy drops at once. Combinational outputs follow their inputs during reset.
- Output values at reset (assuming all inputs are 0): stalls 0, flushE 0, forwards 0, mdbusy 0, stallcnt 0.
- Simultaneous hazards: any single cause asserts stall. stallcnt counts cycles, not causes.

Decomposition:
- Shared package pipe_pkg holds:
  - forward select constants FWD_NONE, FWD_WB, FWD_MEM;
  - the zero-register constant;
  - a default REGW.
- Sub-module md_busy_counter (params MDLAT; ports clk, reset, start, busy) owns mdcnt.
- Forwarding, stall logic and stallcnt stay in the top module.

Test Plan:
- add writes r8 (regwriteM=1, writeregM=8), next instruction uses rsE=8 → forwardAE=2'b10. The same match with writeregM=0 → 2'b00.
- Both M and W write r9, rtE=9 → forwardBE=2'b10. Drop regwriteM → forwardBE=2'b01.
- lw r5 in E (memtoregE=1, regwriteE=1, writeregE=5) with rtD=5 → stallF=stallD=flushE=1 for one cycle; stallcnt goes 0→1.
- beq in D (branchD=1, rsD=3) with a load of r3 in M (memtoregM=1, writeregM=3) → stall=1. Same with writeregM=0 → stall=0.
- MDLAT=4: pulse mdstartE, hold mduseD=1 → mdbusy high for 4 cycles, stall high for those 4 cycles, stallcnt=4, then stall=0.
- Assert reset mid-countdown (mdcnt=2) → mdbusy=0 and stallcnt=0 without a clock edge. PCW=4 with a stall held 20 cycles → stallcnt saturates at 15.
